phase_diff_slicer: RTL and testbench

- Downstream consumer of the CORDIC vectoring stage in the demod chain.
- Takes one 9-bit angle in degrees per CORDIC completion strobe and forms the wrapped phase difference between consecutive angles, i.e. the instantaneous frequency.
- Integrates the differences over one symbol period and slices the sum into a data bit with an erasure flag.
- Delivers the bit over a valid/ready handshake to the bit-sync/framing logic.

---
 rtl/phase_diff_slicer.sv | 149 ++++++++++++++
 tb/tb_phase_diff_slicer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_diff_slicer.sv
// Phase-difference slicer: integrates wrapped angle deltas over one symbol and slices to a bit + erasure.
// Optional freq_est output (acc at each symbol end) enabled by defining PHASE_DIFF_FREQ_EST_EN.
module phase_diff_slicer #(
  parameter int SPS    = 20,
  parameter int ACC_W  = 16,
  parameter int THRESH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       angle_in,
  input  logic             angle_valid,
  input  logic             clear,
  output logic             bit_out,
  output logic             bit_erasure,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             overrun
`ifdef PHASE_DIFF_FREQ_EST_EN
  , output logic signed [ACC_W-1:0] freq_est
`endif
);

  // Sum width covers both the 10-bit delta and the accumulator, plus headroom for one add.
  localparam int SUM_W = ((ACC_W > 10) ? ACC_W : 10) + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((32'sd1 <<< (ACC_W - 1)) - 32'sd1);
  localparam logic signed [SUM_W-1:0] THRESH_S = SUM_W'(THRESH);
  localparam logic [7:0]              LAST_CNT = 8'(SPS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state_r;
  logic [8:0]               prev_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic [7:0]               cnt_r;

  logic [8:0]               a_s;
  logic signed [9:0]        raw_s;
  logic signed [9:0]        d_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [SUM_W-1:0]  acc_ext_s;
  logic signed [SUM_W-1:0]  mag_s;
  logic                     sym_end_s;

  // Normalise the angle, wrap the delta into [-180,179] and form the saturated running sum.
  always_comb begin
    a_s        = 9'd0;
    raw_s      = 10'sd0;
    d_s        = 10'sd0;
    sum_s      = {SUM_W{1'b0}};
    acc_next_s = {ACC_W{1'b0}};
    acc_ext_s  = {SUM_W{1'b0}};
    mag_s      = {SUM_W{1'b0}};
    if (angle_in >= 9'd360) begin
      a_s = angle_in - 9'd360;
    end else begin
      a_s = angle_in;
    end
    raw_s = $signed({1'b0, a_s}) - $signed({1'b0, prev_r});
    if (raw_s > 10'sd179) begin
      d_s = raw_s - 10'sd360;
    end else if (raw_s < -10'sd180) begin
      d_s = raw_s + 10'sd360;
    end else begin
      d_s = raw_s;
    end
    sum_s = SUM_W'(acc_r) + SUM_W'(d_s);
    if (sum_s > SAT_MAX) begin
      acc_next_s = ACC_W'(SAT_MAX);
    end else if (sum_s < -SAT_MAX) begin
      acc_next_s = ACC_W'(-SAT_MAX);
    end else begin
      acc_next_s = ACC_W'(sum_s);
    end
    acc_ext_s = SUM_W'(acc_next_s);
    if (acc_ext_s[SUM_W-1]) begin
      mag_s = -acc_ext_s;
    end else begin
      mag_s = acc_ext_s;
    end
  end

  assign sym_end_s = (state_r == RUN) && angle_valid && (cnt_r == LAST_CNT);

  // Seed/integrate FSM with the bit handshake; clear outranks any same-cycle sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      prev_r      <= 9'd0;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= 8'd0;
      bit_out     <= 1'b0;
      bit_erasure <= 1'b0;
      bit_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear) begin
      state_r   <= IDLE;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= 8'd0;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bit_valid && bit_ready) begin
        bit_valid <= 1'b0;
      end
      if (angle_valid) begin
        prev_r <= a_s;
        case (state_r)
          IDLE: begin
            state_r <= RUN;
          end
          RUN: begin
            if (sym_end_s) begin
              acc_r       <= {ACC_W{1'b0}};
              cnt_r       <= 8'd0;
              bit_out     <= ~acc_next_s[ACC_W-1];
              bit_erasure <= (mag_s < THRESH_S);
              bit_valid   <= 1'b1;
              if (bit_valid && !bit_ready) begin
                overrun <= 1'b1;
              end
            end else begin
              acc_r <= acc_next_s;
              cnt_r <= cnt_r + 8'd1;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PHASE_DIFF_FREQ_EST_EN
  // Frequency estimate follows every symbol end, untouched by clear or the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_est <= {ACC_W{1'b0}};
    end else if (sym_end_s && !clear) begin
      freq_est <= acc_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_phase_diff_slicer.sv
// Directed self-checking bench for phase_diff_slicer (default parameters).
module tb_phase_diff_slicer;

  logic        clk;
  logic        rst_n;
  logic [8:0]  angle_in;
  logic        angle_valid;
  logic        clear;
  logic        bit_out;
  logic        bit_erasure;
  logic        bit_valid;
  logic        bit_ready;
  logic        overrun;
`ifdef PHASE_DIFF_FREQ_EST_EN
  logic signed [15:0] freq_est;
`endif

  int n_checks;
  int n_fail;

  phase_diff_slicer #(.SPS(20), .ACC_W(16), .THRESH(40)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .angle_in   (angle_in),
    .angle_valid(angle_valid),
    .clear      (clear),
    .bit_out    (bit_out),
    .bit_erasure(bit_erasure),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .overrun    (overrun)
`ifdef PHASE_DIFF_FREQ_EST_EN
    , .freq_est (freq_est)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a);
    angle_in    = 9'(a);
    angle_valid = 1'b1;
    tick();
    angle_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic consume();
    bit_ready = 1'b1;
    tick();
    bit_ready = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    angle_in    = 9'd0;
    angle_valid = 1'b0;
    clear       = 1'b0;
    bit_ready   = 1'b0;
    tick();
    check("rst_bit_out", int'(bit_out), 0);
    check("rst_bit_erasure", int'(bit_erasure), 0);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // +10 deg steps: seed, then 20 deltas -> acc 200
    for (int k = 0; k < 20; k++) send(10 * k);
    check("step10_not_yet", int'(bit_valid), 0);
    send(200);
    check("step10_valid", int'(bit_valid), 1);
    check("step10_bit", int'(bit_out), 1);
    check("step10_erasure", int'(bit_erasure), 0);
`ifdef PHASE_DIFF_FREQ_EST_EN
    check("step10_freq_est", int'(freq_est), 200);
`endif
    tick();
    check("step10_hold_valid", int'(bit_valid), 1);
    check("step10_hold_bit", int'(bit_out), 1);
    consume();
    check("step10_consumed", int'(bit_valid), 0);

    // Forward wrap across 0: d = +15 every sample
    do_clear();
    send(350);
    for (int k = 1; k <= 20; k++) send((350 + 15 * k) % 360);
    check("wrapfwd_valid", int'(bit_valid), 1);
    check("wrapfwd_bit", int'(bit_out), 1);
    check("wrapfwd_erasure", int'(bit_erasure), 0);
`ifdef PHASE_DIFF_FREQ_EST_EN
    check("wrapfwd_freq_est", int'(freq_est), 300);
`endif
    consume();

    // Reverse wrap: d = -15 every sample -> acc -300
    do_clear();
    send(35);
    for (int k = 1; k <= 20; k++) send((35 - 15 * k + 720) % 360);
    check("wraprev_valid", int'(bit_valid), 1);
    check("wraprev_bit", int'(bit_out), 0);
    check("wraprev_erasure", int'(bit_erasure), 0);
`ifdef PHASE_DIFF_FREQ_EST_EN
    check("wraprev_freq_est", int'(freq_est), -300);
`endif
    consume();

    // Threshold edges with backpressure: acc +39 then acc -40 with no ready
    do_clear();
    send(0);
    send(39);
    for (int k = 0; k < 19; k++) send(39);
    check("acc39_valid", int'(bit_valid), 1);
    check("acc39_bit", int'(bit_out), 1);
    check("acc39_erasure", int'(bit_erasure), 1);
    check("acc39_overrun", int'(overrun), 0);
    for (int k = 0; k < 20; k++) send(359);
    check("accm40_valid", int'(bit_valid), 1);
    check("accm40_bit", int'(bit_out), 0);
    check("accm40_erasure", int'(bit_erasure), 0);
    check("accm40_overrun", int'(overrun), 1);
    do_clear();
    check("clear_overrun", int'(overrun), 0);
    check("clear_valid", int'(bit_valid), 0);

    // After clear the first sample re-seeds; +1/-1 alternation -> acc 0
    send(100);
    for (int k = 1; k < 20; k++) send((k % 2 == 1) ? 101 : 100);
    check("nearzero_not_yet", int'(bit_valid), 0);
    send(100);
    check("nearzero_valid", int'(bit_valid), 1);
    check("nearzero_bit", int'(bit_out), 1);
    check("nearzero_erasure", int'(bit_erasure), 1);

    // New decision in the same cycle as ready: reload, no overrun
    for (int k = 0; k < 19; k++) send(50);
    check("pending_kept", int'(bit_out), 1);
    bit_ready = 1'b1;
    send(50);
    bit_ready = 1'b0;
    check("sameready_valid", int'(bit_valid), 1);
    check("sameready_bit", int'(bit_out), 0);
    check("sameready_overrun", int'(overrun), 0);
    consume();

    // 365 is treated as 5
    do_clear();
    send(365);
    for (int k = 0; k < 20; k++) send(5);
    check("norm_bit", int'(bit_out), 1);
    check("norm_erasure", int'(bit_erasure), 1);
    consume();

    // clear wins over a same-cycle sample
    angle_in    = 9'd100;
    angle_valid = 1'b1;
    clear       = 1'b1;
    tick();
    angle_valid = 1'b0;
    clear       = 1'b0;
    for (int k = 0; k < 20; k++) send(100);
    check("prio_not_yet", int'(bit_valid), 0);
    send(100);
    check("prio_valid", int'(bit_valid), 1);

    // Async reset mid-cycle drops the pending bit and partial symbol
    for (int k = 0; k < 5; k++) send(120);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", int'(bit_valid), 0);
    check("async_bit", int'(bit_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(0);
    for (int k = 1; k < 20; k++) send(10 * k);
    check("postrst_not_yet", int'(bit_valid), 0);
    send(200);
    check("postrst_valid", int'(bit_valid), 1);
    check("postrst_bit", int'(bit_out), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
